// File: rtl/eth_frame_rx_pkg.sv
// Shared types for the Ethernet byte-stream receiver:
// FSM states, delimiter bytes and the FIFO entry layout.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAYLOAD,
        ST_DROP
    } eth_rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } eth_rx_entry_t;

    localparam int ENTRY_W = $bits(eth_rx_entry_t);

endpackage

// File: rtl/eth_frame_rx_if.sv
// Downstream payload stream of the receiver:
// byte, last/err marking and a valid/ready handshake.
interface eth_frame_rx_if;

    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;
    logic       out_vld;
    logic       out_rdy;

    modport master (
        output out_data,
        output out_last,
        output out_err,
        output out_vld,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_last,
        input  out_err,
        input  out_vld,
        output out_rdy
    );

endinterface

// File: rtl/eth_frame_rx_fifo.sv
// Show-ahead synchronous FIFO of receive entries; a write
// into a full FIFO is accepted only when a read frees a slot.
module eth_rx_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  eth_rx_entry_t          wr_data,
    input  logic                   rd_en,
    output eth_rx_entry_t          rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    eth_rx_entry_t mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/eth_frame_rx.sv
// GMII-style frame receiver: strips preamble/SFD, buffers payload
// through a one-byte hold stage into a FIFO, reports per-frame status.
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter int MIN_PRE = 7,
    parameter int MAX_LEN = 1518,
    parameter int DEPTH   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_dv,
    eth_frame_rx_if.master               m,
    output logic                         frame_done,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         frame_err
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    eth_rx_state_t state;
    eth_rx_state_t state_nx;

    logic [3:0]    pre_cnt;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic [LW-1:0] len;

    eth_rx_entry_t wr_entry;
    eth_rx_entry_t rd_entry;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    logic sfd_ok;
    logic ev_byte;
    logic ev_end;
    logic at_max;
    logic room;
    logic space;
    logic lim;
    logic ovf;
    logic term;
    logic zero;
    logic done_set;
    logic done_err;

    eth_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign m.out_vld  = ~empty;
    assign m.out_data = rd_entry.data;
    assign m.out_last = rd_entry.last;
    assign m.out_err  = rd_entry.err;
    assign pop        = m.out_vld & m.out_rdy;

    // Occupancy seen by this cycle's push, after the same-cycle pop.
    assign room   = (count - CW'(pop)) < CW'(DEPTH - 1);
    assign space  = ~full | pop;
    assign at_max = ({1'b0, len} + (LW+1)'(hold_full)) == (LW+1)'(MAX_LEN);
    assign sfd_ok = (rx_data == SFD_BYTE) && (pre_cnt >= 4'(MIN_PRE));

    assign ev_byte = (state == ST_PAYLOAD) & rx_dv;
    assign ev_end  = (state == ST_PAYLOAD) & ~rx_dv;
    assign lim     = ev_byte & hold_full & at_max;
    assign ovf     = ev_byte & hold_full & ~at_max & ~room;
    assign term    = lim | ovf | (ev_end & hold_full);
    assign zero    = ev_end & ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_dv) begin
                    state_nx = (rx_data == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!rx_dv) begin
                    state_nx = ST_IDLE;
                end else if (rx_data == PREAMBLE_BYTE) begin
                    state_nx = ST_PRE;
                end else if (sfd_ok) begin
                    state_nx = ST_PAYLOAD;
                end else begin
                    state_nx = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (!rx_dv) begin
                    state_nx = ST_IDLE;
                end else if (lim | ovf) begin
                    state_nx = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!rx_dv) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        push          = 1'b0;
        done_set      = 1'b0;
        done_err      = 1'b0;
        wr_entry.data = hold_data;
        wr_entry.last = term;
        wr_entry.err  = lim | ovf;
        unique case (1'b1)
            term: begin
                push     = space;
                done_set = 1'b1;
                done_err = lim | ovf | ~space;
            end
            zero: begin
                done_set = 1'b1;
                done_err = 1'b1;
            end
            (ev_byte & hold_full & ~term): begin
                push = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            len        <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= done_set;
            if (done_set) begin
                frame_len <= len + LW'(push);
                frame_err <= done_err;
            end
            if (push) begin
                len <= len + LW'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    pre_cnt <= 4'd1;
                end
                ST_PRE: begin
                    if (rx_dv && rx_data == PREAMBLE_BYTE && pre_cnt != 4'hF) begin
                        pre_cnt <= pre_cnt + 4'd1;
                    end
                    if (rx_dv && sfd_ok) begin
                        hold_full <= 1'b0;
                        len       <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_dv && !lim && !ovf) begin
                        hold_data <= rx_data;
                        hold_full <= 1'b1;
                    end else begin
                        hold_full <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
